// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the F-stage fetch port and the M-stage data port.
// Optional macro ARB_STARVE_GUARD_EN lets a waiting fetch win after STARVE_MAX back-to-back data grants.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_f,
  output logic          stall_m
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arbStateT;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT);

  if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1) begin : gBadParams
    $error("mem_port_arbiter: MEM_LAT must be 1..15 and STARVE_MAX at least 1");
  end

  arbStateT      state;
  logic [3:0]    cnt;
  logic [DW-1:0] iRdataReg;
  logic [DW-1:0] dRdataReg;
  logic          grantI;
  logic          grantD;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starveCnt;
  logic          starveHit;

  assign starveHit = (starveCnt == SW'(STARVE_MAX));

  // Counts data grants that overtook a waiting fetch; any fetch grant or idle fetch port clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starveCnt <= '0;
    end else if (state == IDLE) begin
      if (grantI || !i_req) begin
        starveCnt <= '0;
      end else if (grantD) begin
        starveCnt <= starveCnt + 1'b1;
      end
    end
  end

  always_comb begin
    grantD = d_req && !(i_req && starveHit);
    grantI = i_req && !grantD;
  end
`else
  always_comb begin
    grantD = d_req;
    grantI = i_req && !d_req;
  end
`endif

  // The access is finished once the latency counter has run down to zero inside a BUSY state.
  assign i_ack = (state == BUSY_I) && (cnt == 4'd0);
  assign d_ack = (state == BUSY_D) && (cnt == 4'd0);

  assign i_rdata = i_ack ? mem_rdata : iRdataReg;
  assign d_rdata = (d_ack && !mem_we) ? mem_rdata : dRdataReg;

  assign stall_f = i_req && !i_ack;
  assign stall_m = d_req && !d_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      iRdataReg <= '0;
      dRdataReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantD) begin
            state     <= BUSY_D;
            cnt       <= CNT_INIT;
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (grantI) begin
            state    <= BUSY_I;
            cnt      <= CNT_INIT;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= i_addr;
          end
        end
        BUSY_I, BUSY_D: begin
          mem_en <= 1'b0;
          if (cnt == 4'd0) begin
            state <= IDLE;
            if (state == BUSY_I) begin
              iRdataReg <= mem_rdata;
            end else if (!mem_we) begin
              dRdataReg <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state  <= IDLE;
          mem_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=2 and one at MEM_LAT=1 sharing the requester inputs.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iReq = 1'b0;
  logic [31:0] iAddr = '0;
  logic        dReq = 1'b0;
  logic        dWe = 1'b0;
  logic [31:0] dAddr = '0;
  logic [31:0] dWdata = '0;

  logic        iAck, dAck, memEn, memWe, stallF, stallM;
  logic [31:0] iRdata, dRdata, memAddr, memWdata, memRdata;
  logic        iAck2, dAck2, memEn2, memWe2, stallF2, stallM2;
  logic [31:0] iRdata2, dRdata2, memAddr2, memWdata2, memRdata2;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the held address, so data is valid by the ack cycle.
  function automatic logic [31:0] memModel(input logic [31:0] a);
    return (a == 32'h40) ? 32'h8C01_0004 : (a ^ 32'hA5A5_0000);
  endfunction

  assign memRdata  = memModel(memAddr);
  assign memRdata2 = memModel(memAddr2);

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(iReq), .i_addr(iAddr), .i_ack(iAck), .i_rdata(iRdata),
    .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata), .d_ack(dAck), .d_rdata(dRdata),
    .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata), .mem_rdata(memRdata),
    .stall_f(stallF), .stall_m(stallM)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dutLat1 (
    .clk(clk), .rst(rst),
    .i_req(iReq), .i_addr(iAddr), .i_ack(iAck2), .i_rdata(iRdata2),
    .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata), .d_ack(dAck2), .d_rdata(dRdata2),
    .mem_en(memEn2), .mem_we(memWe2), .mem_addr(memAddr2), .mem_wdata(memWdata2), .mem_rdata(memRdata2),
    .stall_f(stallF2), .stall_m(stallM2)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                               input logic [31:0] da, input logic [31:0] dwd);
    nextCycle();
    iReq   = ir;
    iAddr  = ia;
    dReq   = dr;
    dWe    = dw;
    dAddr  = da;
    dWdata = dwd;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ackSeq[6];
    int nAcks;
    logic sawD;

    // Reset state
    @(negedge clk);
    checkOutput("rstMemEn", memEn, 0);
    checkOutput("rstMemWe", memWe, 0);
    checkOutput("rstMemAddr", memAddr, 0);
    checkOutput("rstAcks", {iAck, dAck}, 0);
    checkOutput("rstRdata", {iRdata, dRdata}, 0);
    checkOutput("rstLat1MemEn", memEn2, 0);
    nextCycle();
    rst = 1'b1;
    repeat (2) nextCycle();

    // Single fetch
    applyStimulus(1, 32'h40, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("fetchC0Stall", stallF, 1);
    checkOutput("fetchC0En", memEn, 0);
    nextCycle(); @(negedge clk);
    checkOutput("fetchC1En", memEn, 1);
    checkOutput("fetchC1Addr", memAddr, 32'h40);
    checkOutput("fetchC1We", memWe, 0);
    checkOutput("fetchC1Stall", stallF, 1);
    nextCycle(); @(negedge clk);
    checkOutput("fetchC2En", memEn, 0);
    checkOutput("fetchC2Ack", iAck, 0);
    checkOutput("fetchC2Stall", stallF, 1);
    nextCycle(); @(negedge clk);
    checkOutput("fetchC3Ack", iAck, 1);
    checkOutput("fetchC3Rdata", iRdata, 32'h8C01_0004);
    checkOutput("fetchC3Stall", stallF, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("fetchC4Ack", iAck, 0);
    checkOutput("fetchC4Hold", iRdata, 32'h8C01_0004);

    // Load, then a store that must leave d_rdata alone
    applyStimulus(0, 0, 1, 0, 32'h20, 0);
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("loadAck", dAck, 1);
    checkOutput("loadRdata", dRdata, 32'hA5A5_0020);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 32'h10, 32'hDEAD_BEEF);
    nextCycle(); @(negedge clk);
    checkOutput("storeC1En", memEn, 1);
    checkOutput("storeC1We", memWe, 1);
    checkOutput("storeC1Addr", memAddr, 32'h10);
    checkOutput("storeC1Wdata", memWdata, 32'hDEAD_BEEF);
    nextCycle(); @(negedge clk);
    checkOutput("storeC2We", memWe, 1);
    checkOutput("storeC2Wdata", memWdata, 32'hDEAD_BEEF);
    checkOutput("storeC2Stall", stallM, 1);
    nextCycle(); @(negedge clk);
    checkOutput("storeC3Ack", dAck, 1);
    checkOutput("storeC3Rdata", dRdata, 32'hA5A5_0020);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("storeC4Rdata", dRdata, 32'hA5A5_0020);

    // Simultaneous requests: D first, fetch follows
    applyStimulus(1, 32'h44, 1, 0, 32'h24, 0);
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) begin
        nextCycle();
        if (c == 4) dReq = 1'b0;
      end
      @(negedge clk);
      checkOutput($sformatf("conflictStallF%0d", c), stallF, (c <= 6));
      checkOutput($sformatf("conflictDAck%0d", c), dAck, (c == 3));
      checkOutput($sformatf("conflictIAck%0d", c), iAck, (c == 7));
      if (c == 3) checkOutput("conflictDRdata", dRdata, 32'hA5A5_0024);
      if (c == 5) checkOutput("conflictIAddr", memAddr, 32'h44);
    end
    checkOutput("conflictIRdata", iRdata, 32'hA5A5_0044);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Reset in the middle of a store
    applyStimulus(0, 0, 1, 1, 32'h30, 32'h1234_5678);
    nextCycle();
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstEn", memEn, 0);
    checkOutput("midRstWe", memWe, 0);
    checkOutput("midRstAddr", memAddr, 0);
    checkOutput("midRstWdata", memWdata, 0);
    checkOutput("midRstAck", dAck, 0);
    checkOutput("midRstRdata", {iRdata, dRdata}, 0);
    nextCycle();
    dReq = 1'b0;
    @(negedge clk);
    checkOutput("midRstNoAck", dAck, 0);
    nextCycle();
    rst = 1'b1;
    applyStimulus(0, 0, 1, 0, 32'h50, 0);
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("postRstAck", dAck, 1);
    checkOutput("postRstRdata", dRdata, 32'hA5A5_0050);
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (3) nextCycle();

    // MEM_LAT=1 back-to-back loads with d_req held
    applyStimulus(0, 0, 1, 0, 32'h60, 0);
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) nextCycle();
      @(negedge clk);
      checkOutput($sformatf("lat1Ack%0d", c), dAck2, (c == 2 || c == 5));
      if (c == 1) checkOutput("lat1En", memEn2, 1);
    end
    checkOutput("lat1Rdata", dRdata2, 32'hA5A5_0060);
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (5) nextCycle();

    // Both requests held; a new data access after each D ack
    applyStimulus(1, 32'h80, 1, 0, 32'h100, 0);
    nAcks = 0;
    for (int cyc = 0; cyc < 60 && nAcks < 6; cyc++) begin
      @(negedge clk);
      sawD = 1'b0;
      if (dAck) begin
        ackSeq[nAcks] = 0;
        nAcks++;
        sawD = 1'b1;
      end else if (iAck) begin
        ackSeq[nAcks] = 1;
        nAcks++;
      end
      nextCycle();
      if (sawD) dAddr = dAddr + 32'd4;
    end
    checkOutput("starveAckCount", nAcks, 6);
    for (int i = 0; i < nAcks; i++) begin
`ifdef ARB_STARVE_GUARD_EN
      checkOutput($sformatf("starveGrant%0d", i), ackSeq[i], (i == 4) ? 1 : 0);
`else
      checkOutput($sformatf("starveGrant%0d", i), ackSeq[i], 0);
`endif
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (6) nextCycle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared single-port, fixed-latency memory between the pipeline's instruction-fetch (F) and memory-stage (M) requesters in the 5-stage MIPS core.
- Serialises accesses with a small FSM, returns read data with a one-cycle ack, and produces stall_f/stall_m for the hazard logic.
- M-stage requests have priority, because M holds the older instruction.

Parameters:
- AW, 32, address width (byte address, passed through unchanged).
- DW, 32, data width.
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.
- STARVE_MAX, 4, consecutive D grants allowed while i_req waits; used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_req  in  1  F-stage fetch request; held until i_ack.
- i_addr  in  AW  fetch address.
- i_ack  out  1  one-cycle pulse; fetch complete.
- i_rdata  out  DW  fetched instruction.
- d_req  in  1  M-stage access request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_ack  out  1  one-cycle pulse; access complete.
- d_rdata  out  DW  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- stall_f  out  1  i_req & ~i_ack.
- stall_m  out  1  d_req & ~d_ack.

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D. Counter cnt, 4 bits.
- IDLE arbitration:
  - If d_req: go to BUSY_D; latch d_addr, d_wdata and d_we into the mem_* registers.
  - Else if i_req: go to BUSY_I; latch i_addr with mem_we=0.
  - Else stay in IDLE.
  - On either grant, set cnt=MEM_LAT.
- mem_en is registered. It is 1 only in the first BUSY cycle (cycle k).
- mem_addr, mem_we and mem_wdata hold their latched values for the whole BUSY period.
- In each BUSY cycle, cnt decrements. When cnt reaches 0 (cycle k+MEM_LAT):
  - Assert the matching ack for that one cycle.
  - Return to IDLE on the next edge.
- Latency: a request first seen in IDLE at cycle 0 is acked in cycle 1+MEM_LAT. Peak throughput is one access per MEM_LAT+2 cycles.
- Read data:
  - In the ack cycle, the matching rdata output equals mem_rdata.
  - At all other times it holds the last delivered value from an internal register.
  - A store ack does not update d_rdata.
- Simultaneous i_req and d_req in IDLE: D wins. I waits with stall_f=1.
- A request that drops mid-BUSY is not cancelled. The access completes, and the ack still pulses with no side effect.
- A request still high in the IDLE cycle after its ack is treated as a new request. The requester must change or drop it.
- Reset (asserted at any time, including mid-access):
  - state=IDLE, cnt=0, mem_en=0, mem_we=0.
  - mem_addr, mem_wdata, i_rdata and d_rdata = 0.
  - Acks = 0. Any in-flight access is abandoned with no ack.
- stall_f and stall_m are combinational and are 0 whenever their request is low.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A starvation counter increments on each D grant made while i_req=1.
  - It clears on any I grant, or when i_req=0 in IDLE.
  - When the counter equals STARVE_MAX and both requests are present in IDLE, I is granted instead of D.
- Undefined: strict D priority, and no starvation counter is instantiated.

Test Plan:
- Single fetch, MEM_LAT=2: i_req=1 and i_addr=0x40 at cycle 0. Required response: mem_en=1 with mem_addr=0x40 in cycle 1; mem_rdata=0x8C010004 returned in cycle 3; i_ack=1 and i_rdata=0x8C010004 in cycle 3; stall_f=1 in cycles 0-2.
- Store: d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF. Required response: mem_we=1 and mem_wdata=0xDEADBEEF while BUSY; d_ack in cycle 3; d_rdata unchanged.
- Conflict: i_req and d_req both rise at cycle 0. Required response: d_ack in cycle 3, then I granted in IDLE cycle 4 and i_ack in cycle 7; stall_f=1 in cycles 0-6.
- Reset mid-access: rst=0 in cycle 2 of BUSY_D. Required response: all outputs 0 immediately and no d_ack; after release, a fresh d_req completes normally.
- With ARB_STARVE_GUARD_EN and STARVE_MAX=4: d_req and i_req held continuously with a new D access each time. Required response: after 4 d_acks the 5th grant goes to I; without the macro, I is never granted while d_req stays high.
- MEM_LAT=1 back-to-back loads: two consecutive d_req. Required response: acks in cycles 2 and 5.
